// File: rtl/weighted_pulse_gen.sv
// weighted_pulse_gen: switch-weighted pulse-width generator.
// A write request latches the (saturated) sum of the weights of the active
// switches; `out` then stays high for exactly that many prescaler ticks.
// Optional build macro: WPG_ABORT_EN adds an `abort` input that cancels a
// pending or running pulse.
module weighted_pulse_gen #(
  parameter int                             NUM_SW   = 4,
  parameter int                             WEIGHT_W = 8,
  parameter logic [NUM_SW*WEIGHT_W-1:0]     WEIGHTS  = {8'd43, 8'd76, 8'd109, 8'd120},
  parameter int                             CNT_W    = 9,
  parameter int                             TICK_DIV = 5207
) (
  input  logic              sysclk,
  input  logic              rst,
  input  logic              write,
  input  logic [NUM_SW-1:0] sw,
`ifdef WPG_ABORT_EN
  input  logic              abort,
`endif
  output logic              out,
  output logic              out_q,
  output logic              busy,
  output logic              done,
  output logic              tick
);

  // Sum is formed with enough headroom that it can never wrap before saturation.
  localparam int                 SUM_W      = CNT_W + $clog2(NUM_SW);
  localparam int                 PRESC_W    = $clog2(TICK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [SUM_W-1:0]   SAT_MAX    = SUM_W'((64'd1 << CNT_W) - 64'd1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_PULSE, S_DONE} state_t;

  state_t             state_reg;
  state_t             state_next;
  logic [PRESC_W-1:0] presc_reg;
  logic [CNT_W-1:0]   total_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               done_reg;
  logic               out_q_reg;
  logic [SUM_W-1:0]   gated_w [NUM_SW];
  logic [SUM_W-1:0]   raw_sum;
  logic [CNT_W-1:0]   sum_total;
  logic               abort_hit;

`ifdef WPG_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  // Each switch contributes its weight only when it is on.
  generate
    for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_weight
      assign gated_w[gi] = sw[gi] ? SUM_W'(WEIGHTS[gi*WEIGHT_W +: WEIGHT_W]) : '0;
    end
  endgenerate

  // Add the active weights and clamp the result to the counter range.
  always_comb begin
    raw_sum = '0;
    for (int i = 0; i < NUM_SW; i++) begin
      raw_sum = raw_sum + gated_w[i];
    end
    sum_total = (raw_sum > SAT_MAX) ? SAT_MAX[CNT_W-1:0] : raw_sum[CNT_W-1:0];
  end

  // Free-running prescaler; wraps after TICK_DIV cycles.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      presc_reg <= '0;
    end else if (presc_reg == PRESC_LAST) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + 1'b1;
    end
  end

  assign tick = (presc_reg == PRESC_LAST);

  // State register.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; abort outranks a coincident tick.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (write && (sw != '0) && (sum_total != '0)) begin
          state_next = S_ARMED;
        end
      end
      S_ARMED: begin
        if (abort_hit) begin
          state_next = S_DONE;
        end else if (tick) begin
          state_next = S_PULSE;
        end
      end
      S_PULSE: begin
        if (abort_hit) begin
          state_next = S_DONE;
        end else if (tick && (count_reg == total_reg - CNT_W'(1))) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        // Waiting for write to drop is what forces a fresh low->high request.
        if (!write) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Total/count bookkeeping, done strobe and the tick-delayed copy of out.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      total_reg <= '0;
      count_reg <= '0;
      done_reg  <= 1'b0;
      out_q_reg <= 1'b0;
    end else begin
      done_reg <= ((state_reg == S_ARMED) || (state_reg == S_PULSE)) &&
                  (state_next == S_DONE);
      if (tick) begin
        out_q_reg <= out;
      end
      if ((state_reg != S_DONE) && (state_next == S_DONE)) begin
        total_reg <= '0;
        count_reg <= '0;
      end else if ((state_reg == S_IDLE) && (state_next == S_ARMED)) begin
        total_reg <= sum_total;
        count_reg <= '0;
      end else if ((state_reg == S_PULSE) && tick) begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  // Moore outputs straight from the state, so reset clears them at once.
  always_comb begin
    out   = (state_reg == S_PULSE);
    busy  = (state_reg == S_ARMED) || (state_reg == S_PULSE);
    done  = done_reg;
    out_q = out_q_reg;
  end

endmodule
